bcd_updown_counter: RTL
=======================

Name: bcd_updown_counter

Overview:
Parametrised multi-digit BCD up/down counter. It is the successor to the plain 4-bit binary counter and drives the 7-segment display path directly with packed BCD digits. It adds direction control, enable with a built-in prescaler, synchronous clear/load, and wrap or saturate modes. Status flags (terminal carry/borrow, zero, max, load error) support cascading and display control.

Parameters:
DIGITS, 4, number of BCD digits; count width is 4*DIGITS bits; legal range 1..8.
SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.
PRESCALE, 1, number of enabled clocks per count step; legal range 1..65535.

Ports:
clk  input  1  clock, rising-edge.
arst  input  1  reset, asynchronous, active-high.
en  input  1  count enable; advances the prescaler.
up  input  1  direction: 1 = increment, 0 = decrement; sampled on each step.
clr  input  1  synchronous clear.
load  input  1  synchronous parallel load request.
load_val  input  4*DIGITS  packed BCD load value; digit 0 is in bits [3:0].
count  output  4*DIGITS  packed BCD count, registered.
carry  output  1  registered one-cycle pulse on wrap, or on an attempted step past a limit.
zero  output  1  combinational; 1 when count is all zeros.
max  output  1  combinational; 1 when every digit of count is 9.
load_err  output  1  registered one-cycle pulse when a load is rejected.

Behaviour:
- Reset (arst=1, immediate, no clock needed): count=0, carry=0, load_err=0, prescaler=0. zero=1, max=0 follow from count.
- Priority each cycle: clr > load > step. Losers have no effect in that cycle.
- clr: next cycle count=0 and prescaler=0. carry and load_err are 0 that cycle.
- load: if every nibble of load_val is <=9, next cycle count=load_val and prescaler=0.
- load with any nibble >9: count and prescaler unchanged; load_err=1 for exactly one cycle (the cycle after the request).
- Prescaler: internal counter ceil(log2(PRESCALE)) bits wide, minimum 1 bit.
  - Advances only when en=1 and neither clr nor load is asserted.
  - Step occurs when en=1 and prescaler==PRESCALE-1; the prescaler then returns to 0.
  - PRESCALE=1 means a step on every enabled clock.
  - en=0 freezes the prescaler; it is never cleared by en going low.
  - A change of up mid-interval does not reset the prescaler.
- Up step: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit; all digits resolve in the same cycle (count latency 1 clock).
- Up step at all 9s:
  - SATURATE=0: count becomes all 0s.
  - SATURATE=1: count holds at all 9s.
  - Either mode: carry=1 for the cycle the new count is presented.
- Down step: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Down step at all 0s:
  - SATURATE=0: count becomes all 9s.
  - SATURATE=1: count holds at 0.
  - Either mode: carry=1 for one cycle.
- carry is 0 on every other cycle, including cycles with en=0.
- count never holds a nibble >9 under any input sequence after reset.
- arst asserted mid-interval or mid-pulse: all state clears immediately. A pending carry or load_err pulse is lost.
- Release of arst is synchronised externally; the block needs no internal reset synchroniser.

Test Plan:
- DIGITS=2, PRESCALE=1, SATURATE=0: load 0x98, then en=1, up=1 for 3 clocks -> count 0x99, 0x00 (carry=1 this cycle only), 0x01; zero=1 only while count is 0x00.
- Same config, up=0 from reset: first step -> count 0x99, carry=1, max=1; next step -> 0x98, carry=0.
- SATURATE=1: load 0x99, up=1 for 3 steps -> count stays 0x99, carry=1 on each attempted step. Then up=0 -> 0x98.
- Load load_val=0x1A -> load_err=1 for one cycle, count unchanged. Assert clr and load together -> count 0x00, no load_err.
- PRESCALE=3, up=1, en held 1 for 9 clocks from 0 -> count reaches 0x03, changing on clocks 3, 6, 9.
  - Then drop en for 2 clocks mid-interval and resume -> the next step arrives exactly 3 enabled clocks after the previous one.
- Assert arst asynchronously between clock edges while count=0x57 and carry=1 -> count=0, carry=0, zero=1 before the next edge. Counting restarts from 0x00 after release.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit packed-BCD up/down counter with prescaled enable,
// synchronous clear/load, wrap or saturate limits and status flags.
module bcd_updown_counter #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic                  zero,
  output logic                  max,
  output logic                  load_err
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps;
  logic [W-1:0]  inc_val;
  logic [W-1:0]  dec_val;
  logic [W-1:0]  step_val;
  logic          step_lim;
  logic          load_ok;
  logic          ps_wrap;

  // Ripple increment across all digits in one cycle.
  always_comb begin
    logic       c;
    logic [3:0] d;
    inc_val = '0;
    c       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = count[4*i +: 4];
      if (c && d == 4'd9) begin
        inc_val[4*i +: 4] = 4'd0;
      end else if (c) begin
        inc_val[4*i +: 4] = d + 4'd1;
        c = 1'b0;
      end else begin
        inc_val[4*i +: 4] = d;
      end
    end
  end

  // Ripple decrement across all digits in one cycle.
  always_comb begin
    logic       b;
    logic [3:0] d;
    dec_val = '0;
    b       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = count[4*i +: 4];
      if (b && d == 4'd0) begin
        dec_val[4*i +: 4] = 4'd9;
      end else if (b) begin
        dec_val[4*i +: 4] = d - 4'd1;
        b = 1'b0;
      end else begin
        dec_val[4*i +: 4] = d;
      end
    end
  end

  // Status flags and load validity, all digit-wise.
  always_comb begin
    logic m;
    logic ok;
    m  = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count[4*i +: 4] != 4'd9) m = 1'b0;
      if (load_val[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    max     = m;
    load_ok = ok;
    zero    = (count == '0);
  end

  // Choose the post-step value, honouring wrap or saturate at the limits.
  always_comb begin
    step_lim = up ? max : zero;
    step_val = up ? inc_val : dec_val;
    if (step_lim && SATURATE) step_val = count;
  end

  assign ps_wrap = (ps == PS_LAST);

  // Count, prescaler and pulse registers; clr beats load beats step.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count    <= '0;
      ps       <= '0;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        count <= '0;
        ps    <= '0;
      end else if (load) begin
        if (load_ok) begin
          count <= load_val;
          ps    <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (en) begin
        if (ps_wrap) begin
          ps    <= '0;
          count <= step_val;
          carry <= step_lim;
        end else begin
          ps <= ps + PW'(1);
        end
      end
    end
  end

endmodule
